// File: rtl/fetch_pkg.sv
// Shared front-end fetch definitions: sequencer state encoding and address defaults.
// The fetch unit and decode import the same encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

    // Fetch addresses are word aligned; the low two bits of any target are dropped.
    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the fetch front end: one outstanding request,
// back-pressure hold, and jump redirect that drops the response the jump kills.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             data_ok_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [31:0]      inst_addr_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  tgt;
    logic [31:0]  jump_tgt;

    assign jump_tgt    = align_addr(jump_addr_i);
    assign inst_addr_o = pc;
    assign valid_o     = (state == REQ) || (state == KILL);
    assign busy_o      = (state == REQ) || (state == KILL);

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        flush_o = 1'b0;
        case (state)
            REQ:     flush_o = jump_flag_i && data_ok_i;
            HOLD:    flush_o = jump_flag_i;
            KILL:    flush_o = data_ok_i;
            default: flush_o = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            tgt         <= '0;
            fetch_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (jump_flag_i) pc <= jump_tgt;
                    state <= REQ;
                end
                REQ: begin
                    if (jump_flag_i && data_ok_i) begin
                        pc <= jump_tgt;
                    end else if (jump_flag_i) begin
                        tgt   <= jump_tgt;
                        state <= KILL;
                    end else if (data_ok_i) begin
                        if (ready_i) begin
                            pc          <= pc + PC_STEP;
                            fetch_cnt_o <= fetch_cnt_o + CNT_ONE;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (jump_flag_i) begin
                        pc    <= jump_tgt;
                        state <= REQ;
                    end else if (ready_i) begin
                        pc          <= pc + PC_STEP;
                        fetch_cnt_o <= fetch_cnt_o + CNT_ONE;
                        state       <= REQ;
                    end
                end
                KILL: begin
                    // A jump arriving with the killed response overrides the stored target.
                    if (data_ok_i) begin
                        pc    <= jump_flag_i ? jump_tgt : tgt;
                        state <= REQ;
                    end else if (jump_flag_i) begin
                        tgt <= jump_tgt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: response scoreboard plus direct output checks,
// including a second instance reset to the top of the address space.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, jump_flag, data_ok, ready;
    logic [31:0] jump_addr;
    logic        valid, flush, busy;
    logic [31:0] inst_addr;
    logic [31:0] fetch_cnt;

    logic        reset2_n, jump2, data_ok2, ready2;
    logic [31:0] jump2_addr;
    logic        valid2, flush2, busy2;
    logic [31:0] inst_addr2;
    logic [31:0] fetch_cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        flush;
    } resp_t;
    resp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .data_ok_i(data_ok), .ready_i(ready), .valid_o(valid), .inst_addr_o(inst_addr),
        .flush_o(flush), .busy_o(busy), .fetch_cnt_o(fetch_cnt)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset_n(reset2_n), .jump_flag_i(jump2), .jump_addr_i(jump2_addr),
        .data_ok_i(data_ok2), .ready_i(ready2), .valid_o(valid2), .inst_addr_o(inst_addr2),
        .flush_o(flush2), .busy_o(busy2), .fetch_cnt_o(fetch_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [31:0] addr, input logic fl);
        resp_t r;
        r.addr  = addr;
        r.flush = fl;
        exp_q.push_back(r);
    endtask

    // Every completed response is matched against the next expected address/flush pair.
    always @(negedge clk) begin
        if (reset_n && valid && data_ok) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {32'd0, inst_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check("resp_addr", {32'd0, inst_addr}, {32'd0, r.addr});
                check("resp_flush", {63'd0, flush}, {63'd0, r.flush});
            end
        end
    end

    initial begin
        reset_n = 1'b0; jump_flag = 1'b0; jump_addr = '0; data_ok = 1'b0; ready = 1'b0;
        reset2_n = 1'b0; jump2 = 1'b0; jump2_addr = '0; data_ok2 = 1'b0; ready2 = 1'b1;
        step();
        step();

        // Reset state
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_addr", {32'd0, inst_addr}, 64'h8000_0000);
        check("rst_flush", {63'd0, flush}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cnt", {32'd0, fetch_cnt}, 64'd0);
        check("rst_addr_wrap_inst", {32'd0, inst_addr2}, 64'hFFFF_FFFC);

        // Back-to-back fetches from reset
        expect_resp(32'h8000_0000, 1'b0);
        expect_resp(32'h8000_0004, 1'b0);
        expect_resp(32'h8000_0008, 1'b0);
        reset_n = 1'b1; data_ok = 1'b1; ready = 1'b1;
        step();
        check("idle_to_req_valid", {63'd0, valid}, 64'd1);
        step(); step(); step();
        check("b2b_cnt", {32'd0, fetch_cnt}, 64'd3);
        check("b2b_addr", {32'd0, inst_addr}, 64'h8000_000C);

        // Back-pressure: response taken with ready=0, hold for three cycles
        expect_resp(32'h8000_000C, 1'b0);
        ready = 1'b0;
        step();
        data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", {63'd0, valid}, 64'd0);
            check("hold_busy", {63'd0, busy}, 64'd0);
            check("hold_addr", {32'd0, inst_addr}, 64'h8000_000C);
            check("hold_cnt", {32'd0, fetch_cnt}, 64'd3);
            if (i < 2) step();
        end
        ready = 1'b1;
        step();
        check("hold_release_addr", {32'd0, inst_addr}, 64'h8000_0010);
        check("hold_release_cnt", {32'd0, fetch_cnt}, 64'd4);
        check("hold_release_valid", {63'd0, valid}, 64'd1);

        // Jump while the request is still outstanding: kill and redirect (low bits dropped)
        jump_flag = 1'b1; jump_addr = 32'h8000_0103;
        step();
        jump_flag = 1'b0;
        check("kill_valid", {63'd0, valid}, 64'd1);
        check("kill_busy", {63'd0, busy}, 64'd1);
        check("kill_addr", {32'd0, inst_addr}, 64'h8000_0010);
        step();
        expect_resp(32'h8000_0010, 1'b1);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        check("redirect_addr", {32'd0, inst_addr}, 64'h8000_0100);
        check("redirect_cnt", {32'd0, fetch_cnt}, 64'd4);
        check("redirect_flush_low", {63'd0, flush}, 64'd0);

        // Two jumps in KILL: the last one wins
        jump_flag = 1'b1; jump_addr = 32'h8000_0200;
        step();
        jump_addr = 32'h8000_0300;
        step();
        jump_flag = 1'b0;
        check("kill2_addr", {32'd0, inst_addr}, 64'h8000_0100);
        expect_resp(32'h8000_0100, 1'b1);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        check("last_jump_addr", {32'd0, inst_addr}, 64'h8000_0300);
        check("last_jump_cnt", {32'd0, fetch_cnt}, 64'd4);

        // Jump together with data_ok in REQ: immediate redirect
        expect_resp(32'h8000_0300, 1'b1);
        jump_flag = 1'b1; jump_addr = 32'h8000_0400; data_ok = 1'b1;
        step();
        jump_flag = 1'b0; data_ok = 1'b0;
        check("imm_redirect_addr", {32'd0, inst_addr}, 64'h8000_0400);
        check("imm_redirect_valid", {63'd0, valid}, 64'd1);
        check("imm_redirect_cnt", {32'd0, fetch_cnt}, 64'd4);

        // Jump out of HOLD drops the buffered instruction
        expect_resp(32'h8000_0400, 1'b0);
        data_ok = 1'b1; ready = 1'b0;
        step();
        data_ok = 1'b0;
        jump_flag = 1'b1; jump_addr = 32'h8000_0500;
        @(negedge clk);
        check("hold_jump_flush", {63'd0, flush}, 64'd1);
        step();
        jump_flag = 1'b0;
        check("hold_jump_addr", {32'd0, inst_addr}, 64'h8000_0500);
        check("hold_jump_cnt", {32'd0, fetch_cnt}, 64'd4);

        // Reset asserted in HOLD
        expect_resp(32'h8000_0500, 1'b0);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        check("pre_rst_hold_valid", {63'd0, valid}, 64'd0);
        reset_n = 1'b0;
        step();
        check("rst_hold_valid", {63'd0, valid}, 64'd0);
        check("rst_hold_addr", {32'd0, inst_addr}, 64'h8000_0000);
        check("rst_hold_cnt", {32'd0, fetch_cnt}, 64'd0);
        check("rst_hold_busy", {63'd0, busy}, 64'd0);

        // Reset asserted in KILL with the old response arriving
        reset_n = 1'b1;
        step();
        jump_flag = 1'b1; jump_addr = 32'h8000_0600;
        step();
        jump_flag = 1'b0;
        check("pre_rst_kill_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0; data_ok = 1'b1;
        step();
        check("rst_kill_valid", {63'd0, valid}, 64'd0);
        check("rst_kill_addr", {32'd0, inst_addr}, 64'h8000_0000);
        check("rst_kill_cnt", {32'd0, fetch_cnt}, 64'd0);
        check("rst_kill_flush", {63'd0, flush}, 64'd0);

        // Restart after reset: first request one cycle after release
        expect_resp(32'h8000_0000, 1'b0);
        reset_n = 1'b1; ready = 1'b1;
        step();
        step();
        data_ok = 1'b0;
        check("restart_addr", {32'd0, inst_addr}, 64'h8000_0004);
        check("restart_cnt", {32'd0, fetch_cnt}, 64'd1);

        // Address wrap on the instance reset to FFFF_FFFC
        reset2_n = 1'b1; data_ok2 = 1'b1;
        step();
        check("wrap_first_addr", {32'd0, inst_addr2}, 64'hFFFF_FFFC);
        check("wrap_first_valid", {63'd0, valid2}, 64'd1);
        step();
        data_ok2 = 1'b0;
        check("wrap_addr", {32'd0, inst_addr2}, 64'h0000_0000);
        check("wrap_cnt", {32'd0, fetch_cnt2}, 64'd1);

        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
